// File: rtl/exp7_detector_jogada.sv
// Purpose : debounced play/pause button detector feeding the game control unit.
// Latency : play pulse in the cycle after edge t0+N+2 for a press applied before edge t0 (2 sync + N+1 filter samples).
// Backpress: none; jogada_feita is a single-cycle pulse the control unit must take when it appears.
//
// Ports:
//   clock, reset (async, active-low)   limpa        : synchronous clear from the control unit
//   botoes[3:0], botao_pausa           : raw asynchronous buttons, active-high
//   jogada_feita : one-cycle pulse per accepted play   jogada[3:0] : one-hot code of last accepted play
//   pausa_jogo   : pause level, toggled per accepted pause press    db_estado[2:0] : play FSM state
module exp7_detector_jogada #(
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       limpa,
  input  logic [3:0] botoes,
  input  logic       botao_pausa,
  output logic       jogada_feita,
  output logic [3:0] jogada,
  output logic       pausa_jogo,
  output logic [2:0] db_estado
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_ALVO = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  localparam logic [2:0] ESPERA       = 3'd0;
  localparam logic [2:0] FILTRA       = 3'd1;
  localparam logic [2:0] VALIDA       = 3'd2;
  localparam logic [2:0] SEGURA       = 3'd3;
  localparam logic [2:0] FILTRA_SOLTA = 3'd4;
  localparam logic [2:0] INVALIDA     = 3'd5;

  // ---------------------------------------------------------------
  // Two-flop synchronizers; nothing downstream sees the raw inputs.
  // ---------------------------------------------------------------
  logic [3:0] b_meta, s_botoes;
  logic       p_meta, s_pausa;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      b_meta   <= '0;
      s_botoes <= '0;
      p_meta   <= 1'b0;
      s_pausa  <= 1'b0;
    end else begin
      b_meta   <= botoes;
      s_botoes <= b_meta;
      p_meta   <= botao_pausa;
      s_pausa  <= p_meta;
    end
  end

  // ---------------------------------------------------------------
  // Play FSM
  // ---------------------------------------------------------------
  logic [2:0]    estado, estado_prox;
  logic [CW-1:0] cont, cont_prox, cont_inc;
  logic [3:0]    codigo, codigo_prox;
  logic          carrega_jogada;
  logic          um_botao, varios_botoes, nenhum_botao;

  assign nenhum_botao  = (s_botoes == 4'd0);
  // Exactly one bit set: nonzero and clearing the lowest set bit leaves zero.
  assign um_botao      = !nenhum_botao && ((s_botoes & (s_botoes - 4'd1)) == 4'd0);
  assign varios_botoes = !nenhum_botao && !um_botao;
  assign cont_inc      = (cont == CNT_MAX) ? cont : cont + 1'b1;

  always_comb begin
    estado_prox    = estado;
    cont_prox      = cont;
    codigo_prox    = codigo;
    carrega_jogada = 1'b0;
    case (estado)
      ESPERA: begin
        cont_prox = '0;
        if (um_botao) begin
          estado_prox = FILTRA;
          codigo_prox = s_botoes;
        end else if (varios_botoes) begin
          estado_prox = INVALIDA;
        end
      end
      FILTRA: begin
        if (s_botoes == codigo) begin
          if (cont == CNT_ALVO) begin
            estado_prox    = VALIDA;
            carrega_jogada = 1'b1;
          end else begin
            cont_prox = cont_inc;
          end
        end else begin
          estado_prox = ESPERA;
          cont_prox   = '0;
        end
      end
      VALIDA: estado_prox = SEGURA;
      SEGURA: begin
        if (nenhum_botao) begin
          estado_prox = FILTRA_SOLTA;
          cont_prox   = '0;
        end
      end
      FILTRA_SOLTA: begin
        if (nenhum_botao) begin
          if (cont == CNT_ALVO) begin
            estado_prox = ESPERA;
            cont_prox   = '0;
          end else begin
            cont_prox = cont_inc;
          end
        end else begin
          estado_prox = SEGURA;
        end
      end
      INVALIDA: begin
        if (nenhum_botao) begin
          estado_prox = FILTRA_SOLTA;
          cont_prox   = '0;
        end
      end
      default: begin
        estado_prox = ESPERA;
        cont_prox   = '0;
      end
    endcase
  end

  // limpa parks the FSM in INVALIDA so a button still held from the previous
  // round must be released (and debounced) before it can count again.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado <= ESPERA;
      cont   <= '0;
      codigo <= '0;
      jogada <= '0;
    end else if (limpa) begin
      estado <= INVALIDA;
      cont   <= '0;
      jogada <= '0;
    end else begin
      estado <= estado_prox;
      cont   <= cont_prox;
      codigo <= codigo_prox;
      if (carrega_jogada) begin
        jogada <= codigo;
      end
    end
  end

  assign jogada_feita = (estado == VALIDA) && !limpa;
  assign db_estado    = estado;

  // ---------------------------------------------------------------
  // Pause path: pausa_filtrada follows s_pausa only after N consecutive
  // differing samples; each accepted rising change toggles pausa_jogo.
  // The filtered level survives limpa so a held pause button cannot retoggle.
  // ---------------------------------------------------------------
  logic          pausa_filtrada;
  logic [CW-1:0] cont_pausa;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pausa_filtrada <= 1'b0;
      cont_pausa     <= '0;
      pausa_jogo     <= 1'b0;
    end else if (limpa) begin
      cont_pausa <= '0;
      pausa_jogo <= 1'b0;
    end else if (s_pausa != pausa_filtrada) begin
      if (cont_pausa == CNT_ALVO) begin
        pausa_filtrada <= s_pausa;
        cont_pausa     <= '0;
        if (s_pausa) begin
          pausa_jogo <= ~pausa_jogo;
        end
      end else begin
        cont_pausa <= (cont_pausa == CNT_MAX) ? cont_pausa : cont_pausa + 1'b1;
      end
    end else begin
      cont_pausa <= '0;
    end
  end

endmodule

// File: tb/tb_exp7_detector_jogada.sv
module tb_exp7_detector_jogada;

  localparam int N = 4;

  localparam int M_ESPERA   = 0;
  localparam int M_FILTRA   = 1;
  localparam int M_VALIDA   = 2;
  localparam int M_SEGURA   = 3;
  localparam int M_SOLTA    = 4;
  localparam int M_INVALIDA = 5;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       limpa = 1'b0;
  logic [3:0] botoes = 4'd0;
  logic       botao_pausa = 1'b0;
  logic       jogada_feita;
  logic [3:0] jogada;
  logic       pausa_jogo;
  logic [2:0] db_estado;

  exp7_detector_jogada #(.DEBOUNCE_CYCLES(N)) dut (
    .clock        (clock),
    .reset        (reset),
    .limpa        (limpa),
    .botoes       (botoes),
    .botao_pausa  (botao_pausa),
    .jogada_feita (jogada_feita),
    .jogada       (jogada),
    .pausa_jogo   (pausa_jogo),
    .db_estado    (db_estado)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Two-deep sample queues stand in for the synchronizers; the play side is
  // described by which phase of a press we are in and how many qualifying
  // samples have been seen in that phase.
  int         m_mode, m_run, m_prun;
  logic [3:0] m_code, m_jog, m_s1, m_s2;
  logic       m_p1, m_p2, m_plev, m_pj;

  task automatic mreset();
    m_mode = M_ESPERA; m_run = 0; m_prun = 0;
    m_code = 0; m_jog = 0; m_s1 = 0; m_s2 = 0;
    m_p1 = 0; m_p2 = 0; m_plev = 0; m_pj = 0;
  endtask

  task automatic model_step();
    logic [3:0] sb;
    logic       sp;
    sb = m_s2; sp = m_p2;
    m_s2 = m_s1; m_s1 = botoes;
    m_p2 = m_p1; m_p1 = botao_pausa;
    if (limpa) begin
      m_mode = M_INVALIDA; m_jog = 0; m_pj = 0; m_run = 0; m_prun = 0;
      return;
    end
    case (m_mode)
      M_ESPERA: begin
        if ($countones(sb) == 1) begin m_mode = M_FILTRA; m_code = sb; m_run = 0; end
        else if (sb != 0) m_mode = M_INVALIDA;
      end
      M_FILTRA: begin
        if (sb == m_code) begin
          m_run++;
          if (m_run == N) begin m_mode = M_VALIDA; m_jog = m_code; end
        end else m_mode = M_ESPERA;
      end
      M_VALIDA: m_mode = M_SEGURA;
      M_SEGURA: if (sb == 0) begin m_mode = M_SOLTA; m_run = 0; end
      M_SOLTA: begin
        if (sb == 0) begin
          m_run++;
          if (m_run == N) m_mode = M_ESPERA;
        end else m_mode = M_SEGURA;
      end
      M_INVALIDA: if (sb == 0) begin m_mode = M_SOLTA; m_run = 0; end
      default: m_mode = M_ESPERA;
    endcase
    if (sp != m_plev) begin
      m_prun++;
      if (m_prun == N) begin
        m_plev = sp; m_prun = 0;
        if (sp) m_pj = !m_pj;
      end
    end else m_prun = 0;
  endtask

  // Compare process: every negedge while out of reset.
  always @(negedge clock) begin
    if (reset) begin
      chk("jogada_feita", int'(jogada_feita), int'(m_mode == M_VALIDA && !limpa));
      chk("jogada", int'(jogada), int'(m_jog));
      chk("pausa_jogo", int'(pausa_jogo), int'(m_pj));
      chk("db_estado", int'(db_estado), m_mode);
    end
  end

  int tick_idx, pulses, last_pulse;

  task automatic tick();
    @(posedge clock);
    if (reset) model_step();
    @(negedge clock);
    #1;
    tick_idx++;
    if (jogada_feita) begin pulses++; last_pulse = tick_idx; end
  endtask

  task automatic start_scn();
    pulses = 0; last_pulse = -1; tick_idx = -1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not end, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    mreset();
    start_scn();
    #2;
    chk("rst_feita", int'(jogada_feita), 0);
    chk("rst_jogada", int'(jogada), 0);
    chk("rst_pausa", int'(pausa_jogo), 0);
    chk("rst_estado", int'(db_estado), 0);
    @(negedge clock); #1; reset = 1'b1;
    repeat (3) tick();

    // Single clean press: pulse exactly after edge t0+6.
    start_scn();
    botoes = 4'b0100;
    repeat (20) tick();
    chk("press_pulses", pulses, 1);
    chk("press_pulse_tick", last_pulse, 6);
    chk("press_jogada", int'(jogada), 4'b0100);
    chk("model_jog", int'(m_jog), 4'b0100);
    botoes = 4'b0000;
    repeat (10) tick();
    chk("release_estado", int'(db_estado), 0);

    // Bounce shorter than the filter.
    start_scn();
    botoes = 4'b0010;
    repeat (3) tick();
    botoes = 4'b0000;
    repeat (12) tick();
    chk("bounce_pulses", pulses, 0);
    chk("bounce_jogada", int'(jogada), 4'b0100);
    chk("bounce_estado", int'(db_estado), 0);

    // Two buttons at once.
    start_scn();
    botoes = 4'b0011;
    repeat (10) tick();
    chk("multi_estado_hold", int'(db_estado), 5);
    repeat (10) tick();
    botoes = 4'b0000;
    repeat (2) tick();
    chk("multi_estado_sync", int'(db_estado), 5);
    tick();
    chk("multi_estado_solta", int'(db_estado), 4);
    chk("model_mode_solta", m_mode, M_SOLTA);
    repeat (4) tick();
    chk("multi_estado_fim", int'(db_estado), 0);
    chk("multi_pulses", pulses, 0);

    // Extra button during SEGURA, then a new play.
    start_scn();
    botoes = 4'b0001;
    repeat (10) tick();
    chk("seq_jogada1", int'(jogada), 4'b0001);
    botoes = 4'b1001;
    repeat (10) tick();
    chk("seq_segura", int'(db_estado), 3);
    chk("seq_pulses_mid", pulses, 1);
    botoes = 4'b0000;
    repeat (10) tick();
    botoes = 4'b1000;
    repeat (10) tick();
    chk("seq_pulses", pulses, 2);
    chk("seq_jogada2", int'(jogada), 4'b1000);
    botoes = 4'b0000;
    repeat (10) tick();

    // Pause toggling and limpa.
    botao_pausa = 1'b1; repeat (10) tick();
    botao_pausa = 1'b0; repeat (10) tick();
    chk("pausa_on", int'(pausa_jogo), 1);
    botao_pausa = 1'b1; repeat (10) tick();
    botao_pausa = 1'b0; repeat (10) tick();
    chk("pausa_off", int'(pausa_jogo), 0);
    botao_pausa = 1'b1; repeat (10) tick();
    botao_pausa = 1'b0; repeat (10) tick();
    chk("pausa_on2", int'(pausa_jogo), 1);
    limpa = 1'b1;
    tick();
    limpa = 1'b0;
    chk("limpa_pausa", int'(pausa_jogo), 0);
    chk("limpa_jogada", int'(jogada), 0);
    chk("limpa_estado", int'(db_estado), 5);
    repeat (10) tick();
    chk("limpa_fim", int'(db_estado), 0);

    // Reset during FILTRA, then a fresh press while held.
    start_scn();
    botoes = 4'b0010;
    repeat (4) tick();
    chk("filtra_estado", int'(db_estado), 1);
    #2; reset = 1'b0; mreset();
    #1;
    chk("rstf_feita", int'(jogada_feita), 0);
    chk("rstf_estado", int'(db_estado), 0);
    @(negedge clock); #1; reset = 1'b1;
    start_scn();
    repeat (10) tick();
    chk("rstf_pulses", pulses, 1);
    chk("rstf_pulse_tick", last_pulse, 6);
    botoes = 4'b0000;
    repeat (10) tick();

    // Reset while in VALIDA: pulse disappears immediately.
    start_scn();
    botoes = 4'b0100;
    repeat (7) tick();
    chk("valida_feita", int'(jogada_feita), 1);
    #2; reset = 1'b0; mreset(); botoes = 4'b0000;
    #1;
    chk("rstv_feita", int'(jogada_feita), 0);
    chk("rstv_jogada", int'(jogada), 0);
    @(negedge clock); #1; reset = 1'b1;
    start_scn();
    repeat (10) tick();
    chk("rstv_pulses", pulses, 0);

    // Randomized traffic against the model.
    for (int seg = 0; seg < 400; seg++) begin
      int r, hold;
      r = $urandom_range(0, 9);
      hold = $urandom_range(1, 12);
      if (r < 4) botoes = 4'b0000;
      else if (r < 8) botoes = 4'b0001 << $urandom_range(0, 3);
      else botoes = 4'($urandom_range(1, 15));
      if ($urandom_range(0, 2) == 0) botao_pausa = ~botao_pausa;
      for (int c = 0; c < hold; c++) begin
        limpa = ($urandom_range(0, 99) == 0);
        tick();
      end
    end
    limpa = 1'b0;
    botoes = 4'b0000;
    repeat (5) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/exp7_detector_jogada.md
EXP7_DETECTOR_JOGADA -- requirements
Module: exp7_detector_jogada

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000, number of consecutive stable synchronized samples (N >= 2) required to accept a press, release or pause press.
REQ-002 clock  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; one clock domain only.
REQ-004 limpa  input  1  synchronous clear, active-high (driven by the control unit's inicializa_elementos).
REQ-005 botoes  input  4  raw asynchronous play buttons, active-high.
REQ-006 botao_pausa  input  1  raw asynchronous pause button, active-high.
REQ-007 jogada_feita  output  1  one-cycle pulse per accepted play, consumed by the control unit.
REQ-008 jogada  output  4  one-hot code of the last accepted play, registered.
REQ-009 pausa_jogo  output  1  pause level, toggled by each accepted pause press.
REQ-010 db_estado  output  3  current play-FSM state encoding, for debug.

Function
REQ-011 botoes and botao_pausa SHALL each pass through a 2-flop synchronizer before any other logic; only synchronized values (s_botoes, s_pausa) are used.
REQ-012 The play FSM SHALL have states ESPERA=0, FILTRA=1, VALIDA=2, SEGURA=3, FILTRA_SOLTA=4, INVALIDA=5; all other codes go to ESPERA.
REQ-013 ESPERA: if s_botoes is exactly one-hot -> FILTRA, capture s_botoes into internal code, counter=0; if zero -> stay; if more than one bit set -> INVALIDA.
REQ-014 FILTRA: if s_botoes==code, counter increments; when counter==N-1 and s_botoes==code -> VALIDA; any mismatch -> ESPERA, counter=0.
REQ-015 VALIDA: lasts exactly one cycle; jogada_feita=1; jogada<=code on entry; -> SEGURA.
REQ-016 SEGURA: stay while s_botoes!=0; on s_botoes==0 -> FILTRA_SOLTA, counter=0.
REQ-017 FILTRA_SOLTA: counter increments while s_botoes==0; at counter==N-1 with s_botoes==0 -> ESPERA; any nonzero -> SEGURA.
REQ-018 INVALIDA: no pulse; stay until s_botoes==0, then -> FILTRA_SOLTA.
REQ-019 Latency: with botoes stable one-hot from edge t0 on, jogada_feita SHALL be high exactly in the cycle after edge t0+N+2 and in no other cycle until a full debounced release occurs.
REQ-020 Pressing a second button while in SEGURA SHALL NOT generate a pulse; a new play requires debounced all-released first.
REQ-021 Pause path: independent counter; a rising s_pausa held stable N consecutive samples toggles pausa_jogo once; another toggle requires s_pausa low for N consecutive samples.
REQ-022 Play and pause paths SHALL operate concurrently; simultaneous accepted play and pause in the same cycle both take effect.
REQ-023 Counters SHALL be ceil(log2(N))+1 bits and saturate, never wrap.
REQ-024 limpa=1 SHALL, at the next edge, force play FSM to INVALIDA (so held buttons require release), clear jogada to 0, pausa_jogo to 0, both counters to 0, and suppress jogada_feita that cycle; limpa takes priority over all transitions.

Reset
REQ-025 reset=0 SHALL immediately force play FSM to ESPERA, jogada=0, jogada_feita=0, pausa_jogo=0, db_estado=0, counters and synchronizer flops to 0, regardless of clock.
REQ-026 Reset deasserted mid-press SHALL be treated as a fresh press: pulse only after full N+2 cycle filtering.

Verification (N=4)
REQ-027 botoes=4'b0100 applied before edge t0 and held -> jogada_feita high only in cycle after edge t0+6, jogada=4'b0100 from then on.
REQ-028 botoes=4'b0010 for 3 cycles then 0 (bounce) -> no pulse, jogada unchanged, FSM back to ESPERA.
REQ-029 botoes=4'b0011 held 20 cycles then 0 -> no pulse, db_estado=5 until release, then 4, then 0.
REQ-030 Press 4'b0001 held, add 4'b1000 during SEGURA, release all, press 4'b1000 -> exactly two pulses, jogada=4'b0001 then 4'b1000.
REQ-031 botao_pausa high 10 cycles, low 10, high 10 -> pausa_jogo 0->1->0; limpa pulse while pausa_jogo=1 -> pausa_jogo=0 next edge.
REQ-032 reset=0 asserted asynchronously during FILTRA and in VALIDA -> outputs zero immediately, no pulse emitted.
